// File: rtl/job_io_sr.sv
// job_io_sr: byte-serial job loader and result unloader on one clock.
// Define JOB_CSUM_EN to append a checksum beat to every job frame.
module job_io_sr #(
    parameter int DATA_W    = 8,
    parameter int JOB_BEATS = 80,
    parameter int RES_BEATS = 8,
    parameter int CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          job_clr,
    input  logic                          job_ack,
    output logic [JOB_BEATS*DATA_W-1:0]   job_data,
    output logic                          job_valid,
    output logic                          wr_ovf,
    output logic                          csum_err,
    input  logic                          res_load,
    input  logic [RES_BEATS*DATA_W-1:0]   res_in,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             data_out,
    output logic                          res_pending,
    output logic                          rd_unf
);
    localparam int JW = JOB_BEATS * DATA_W;
    localparam int RW = RES_BEATS * DATA_W;
`ifdef JOB_CSUM_EN
    localparam int FRAME = JOB_BEATS + 1;
`else
    localparam int FRAME = JOB_BEATS;
`endif

    typedef enum logic {COLLECT, HOLD} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic [RW-1:0] res_sr;
    logic accept, last, frame_ok;

    assign accept    = wr_en && state == COLLECT && !job_clr;
    assign last      = accept && wr_cnt == CNT_W'(FRAME - 1);
    assign job_valid = state == HOLD;

`ifdef JOB_CSUM_EN
    logic [DATA_W-1:0] sum, sum_nx;
    assign sum_nx   = sum + data_in;
    assign frame_ok = sum_nx == '0;
    always_ff @(posedge clk) begin
        if (rst || job_clr) sum <= '0;
        else if (accept) sum <= last ? '0 : sum_nx;
        csum_err <= !rst && last && !frame_ok;
    end
`else
    assign frame_ok = 1'b1;
    assign csum_err = 1'b0;
`endif

    always_comb begin
        state_nx = job_clr ? COLLECT : state == HOLD ? (job_ack ? COLLECT : HOLD) : (last && frame_ok) ? HOLD : COLLECT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= COLLECT;
            wr_cnt   <= '0;
            job_data <= '0;
            wr_ovf   <= 1'b0;
        end else begin
            state  <= state_nx;
            wr_cnt <= (job_clr || last) ? '0 : accept ? wr_cnt + 1'b1 : wr_cnt;
            // the checksum beat lands past JOB_BEATS and is never shifted in
            if (accept && wr_cnt < CNT_W'(JOB_BEATS)) job_data <= {job_data[JW-DATA_W-1:0], data_in};
            if (wr_en && state == HOLD && !job_clr) wr_ovf <= 1'b1;
        end
    end

    assign data_out    = res_sr[RW-1 -: DATA_W];
    assign res_pending = rd_cnt != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_sr <= '0;
            rd_cnt <= '0;
            rd_unf <= 1'b0;
        end else if (res_load) begin
            res_sr <= res_in;
            rd_cnt <= CNT_W'(RES_BEATS);
        end else if (rd_en) begin
            if (res_pending) begin
                res_sr <= {res_sr[RW-DATA_W-1:0], {DATA_W{1'b0}}};
                rd_cnt <= rd_cnt - 1'b1;
            end else begin
                rd_unf <= 1'b1;
            end
        end
    end
endmodule

// File: doc/job_io_sr.md
Name: job_io_sr

Overview:
Clocked, parametrised replacement for the miner's byte-serial job loader and result unloader, combined in one block on a single clock. The job path shifts host bytes into a wide job word (blob & target) and frames them with a byte counter and a valid/ack handshake. The result path parallel-loads a hash/nonce word and shifts it out one byte per read strobe, MSB first, with pending and underflow tracking. The block sits between the host byte interface (strobes already synchronised to clk) and the hashing core.

Parameters:
DATA_W, 8, width of one serial beat in bits
JOB_BEATS, 80, beats per job frame; job word width = JOB_BEATS*DATA_W (640 at defaults)
RES_BEATS, 8, beats per result; result word width = RES_BEATS*DATA_W (64 at defaults)
CNT_W, 8, width of the beat counters; must satisfy 2^CNT_W > JOB_BEATS+1 and 2^CNT_W > RES_BEATS

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  one-cycle strobe: accept data_in as the next job beat
data_in  in  DATA_W  job beat
job_clr  in  1  re-frame: clear the job beat counter and job_valid
job_ack  in  1  core has taken job_data
job_data  out  JOB_BEATS*DATA_W  assembled job; first beat written ends up in the MSBs
job_valid  out  1  complete job held, level until acked
wr_ovf  out  1  sticky: a write was attempted while job_valid=1
csum_err  out  1  one-cycle pulse: frame checksum failed (JOB_CSUM_EN only; else constant 0)
res_load  in  1  one-cycle strobe: capture res_in
res_in  in  RES_BEATS*DATA_W  result (hash & nonce)
rd_en  in  1  one-cycle strobe: advance to the next result beat
data_out  out  DATA_W  current result beat
res_pending  out  1  beats remain to be read
rd_unf  out  1  sticky: rd_en seen while res_pending=0

Behaviour:
- Reset (rst=1 at a clk edge): job_data=0, job_valid=0, wr_ovf=0, csum_err=0, data_out=0, res_pending=0, rd_unf=0. Both counters are cleared. Reset overrides every other input, including mid-frame and mid-readout.
- Job path:
  - When wr_en=1 and job_valid=0: job_data <= {job_data[top-DATA_W:0], data_in}, and wr_cnt increments.
  - When the FRAME-th beat is accepted (FRAME = JOB_BEATS): job_valid rises the next cycle, i.e. 1-cycle latency, and wr_cnt returns to 0.
  - While job_valid=1: wr_en is ignored (job_data frozen) and sets wr_ovf.
  - job_ack=1 clears job_valid. job_data is retained. A wr_en in the same cycle as job_ack is still ignored and sets wr_ovf.
  - job_clr=1 clears wr_cnt and job_valid and does not touch job_data. It has priority over wr_en and job_ack in the same cycle.
  - Counter states: COLLECT (wr_cnt 0..FRAME-1, job_valid=0) and HOLD (job_valid=1). COLLECT goes to HOLD on the final beat. HOLD goes to COLLECT on job_ack or job_clr.
- Result path:
  - res_load=1: shift register <= res_in; data_out <= top beat of res_in; rd_cnt <= RES_BEATS; res_pending <= 1.
  - rd_en=1 with rd_cnt>0: shift left by DATA_W, zero-filling; data_out <= next beat; rd_cnt decrements. On the RES_BEATS-th read, data_out becomes 0 and res_pending drops.
  - rd_en with res_pending=0: no state change except rd_unf <= 1.
  - res_load and rd_en in the same cycle: the load wins and the read is discarded.
- Sticky flags: wr_ovf and rd_unf clear only on rst.
- The job and result paths are fully independent; simultaneous activity on both is legal.

Optional Feature:
JOB_CSUM_EN
- Defined: FRAME = JOB_BEATS+1. The extra final beat is a checksum and is not shifted into job_data.
  - The frame is accepted only if the sum of all FRAME beats mod 2^DATA_W equals 0.
  - On mismatch: job_valid stays 0, csum_err pulses for one cycle, wr_cnt is cleared, and job_data keeps the shifted payload.
- Undefined: FRAME = JOB_BEATS, no checksum logic is built, and csum_err is tied to 0.

Test Plan:
- Reset, then write 80 beats 0x00..0x4F -> job_valid=1 one cycle after the last write; job_data[639:632]=0x00, job_data[7:0]=0x4F.
- With job_valid=1, wr_en with 0xAA -> job_data unchanged, wr_ovf=1. Then job_ack -> job_valid=0; write 80 new beats -> job_valid=1 again.
- Write 37 beats, assert job_clr, then write 80 beats 0xFF -> job_valid after exactly 80 beats; job_data all ones.
- res_load with 0x0123456789ABCDEF -> data_out=0x01. Eight rd_en strobes give data_out 0x23,0x45,0x67,0x89,0xAB,0xCD,0xEF,0x00; res_pending falls after the 8th. A 9th rd_en -> rd_unf=1.
- After 3 reads of one result, res_load 0xFFFF0000FFFF0000 together with rd_en in the same cycle -> data_out=0xFF, rd_cnt=8. Separately, assert rst at beat 40 of a job and mid-readout -> every output is at its reset value on the next cycle.
- JOB_CSUM_EN: 80 beats of 0x01 followed by checksum 0xB0 -> job_valid=1. The same payload with checksum 0xB1 -> csum_err pulses once, job_valid stays 0.
